// File: rtl/alu_pkg.sv
// alu_pkg: op-code fields, shift/arith sub-op codes and FSM encoding shared by the ALU files.
package alu_pkg;
   localparam logic [1:0] OP_SHIFT = 2'b00;
   localparam logic [1:0] OP_ARITH = 2'b01;
   localparam logic [1:0] OP_REV   = 2'b10;
   localparam logic [1:0] OP_SLBI  = 2'b11;
   localparam logic [1:0] SH_ROL   = 2'b00;
   localparam logic [1:0] SH_SLL   = 2'b01;
   localparam logic [1:0] SH_ROR   = 2'b10;
   localparam logic [1:0] SH_SRL   = 2'b11;
   localparam logic [1:0] AR_ADD   = 2'b00;
   localparam logic [1:0] AR_AND   = 2'b01;
   localparam logic [1:0] AR_XOR   = 2'b10;
   localparam logic [1:0] AR_MUL   = 2'b11;
   typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle, WIDTH cycles after start.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_prod_lo,
   output logic             o_hi_nz
);
   localparam int CW = $clog2(WIDTH) + 1;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic [2*WIDTH-1:0] r_acc, r_mcand, w_acc_nxt;
   logic [WIDTH-1:0]   r_mplier;
   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign o_done    = r_busy & (r_cnt == CW'(WIDTH - 1));
   // the final partial sum is exposed combinationally so the caller can register it on the done edge
   assign o_prod_lo = w_acc_nxt[WIDTH-1:0];
   assign o_hi_nz   = |w_acc_nxt[2*WIDTH-1:WIDTH];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_mplier <= i_b;
      end else if (r_busy) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (o_done) r_busy <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_pipe_nb.sv
// alu_pipe_nb: valid/ready ALU with registered result and flags.
// Define ALU_MUL_EN to compile in the iterative multiply (op 0111) and its FSM.
module alu_pipe_nb
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       op,
   input  logic             neg1,
   input  logic             neg2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             cOut,
   output logic             ofl,
   output logic             zero,
   output logic             gZero
);
   localparam int LG = $clog2(WIDTH);
   logic [WIDTH-1:0] w_a, w_b, w_rol, w_ror, w_shift, w_arith, w_rev, w_res, w_ld_out, w_mul_lo;
   logic [LG-1:0]    w_sh;
   logic [LG:0]      w_inv;
   logic [WIDTH:0]   w_sum;
   logic             w_is_add, w_acc, w_load, w_ofl, w_ld_cout, w_ld_ofl, w_ld_zero;
   logic             w_mul_done, w_mul_hi;
   logic [WIDTH-1:0] r_out;
   logic             r_out_valid, r_cout, r_ofl, r_zero, r_gzero;
   assign w_a   = neg1 ? -in1 : in1;
   assign w_b   = neg2 ? ~in2 : in2;
   assign w_sh  = w_b[LG-1:0];
   // a shift by WIDTH yields zero, so rotate-by-0 collapses cleanly to a
   assign w_inv = (LG+1)'(WIDTH) - {1'b0, w_sh};
   assign w_rol = (w_a << w_sh) | (w_a >> w_inv);
   assign w_ror = (w_a >> w_sh) | (w_a << w_inv);
   assign w_shift = (op[1:0] == SH_ROL) ? w_rol :
                    (op[1:0] == SH_SLL) ? w_a << w_sh :
                    (op[1:0] == SH_ROR) ? w_ror : w_a >> w_sh;
   assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
   assign w_arith = (op[1:0] == AR_ADD) ? w_sum[WIDTH-1:0] :
                    (op[1:0] == AR_AND) ? w_a & w_b :
                    (op[1:0] == AR_XOR) ? w_a ^ w_b : '0;
   for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign w_rev[i] = w_a[WIDTH-1-i];
   end
   assign w_res = (op[3:2] == OP_SHIFT) ? w_shift :
                  (op[3:2] == OP_ARITH) ? w_arith :
                  (op[3:2] == OP_REV)   ? w_rev : {w_a[WIDTH/2-1:0], w_b[WIDTH/2-1:0]};
   assign w_is_add = op == {OP_ARITH, AR_ADD};
   assign w_ofl    = w_is_add & (w_a[WIDTH-1] == w_b[WIDTH-1]) & (w_sum[WIDTH-1] != w_a[WIDTH-1]);
   assign w_acc    = in_valid & in_ready;
`ifdef ALU_MUL_EN
   state_t r_state;
   logic   w_is_mul;
   assign w_is_mul = op == {OP_ARITH, AR_MUL};
   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_acc & w_is_mul),
      .i_a       (w_a),
      .i_b       (w_b),
      .o_done    (w_mul_done),
      .o_prod_lo (w_mul_lo),
      .o_hi_nz   (w_mul_hi)
   );
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else if (r_state == ST_IDLE && w_acc && w_is_mul) r_state <= ST_MUL;
      else if (r_state == ST_MUL && w_mul_done) r_state <= ST_IDLE;
   end
   assign in_ready = (r_state == ST_IDLE) & (~r_out_valid | out_ready);
   assign w_load   = (w_acc & ~w_is_mul) | w_mul_done;
`else
   assign w_mul_done = 1'b0;
   assign w_mul_lo   = '0;
   assign w_mul_hi   = 1'b0;
   assign in_ready   = ~r_out_valid | out_ready;
   assign w_load     = w_acc;
`endif
   assign w_ld_out  = w_mul_done ? w_mul_lo : w_res;
   assign w_ld_cout = w_mul_done ? w_mul_hi : w_is_add & w_sum[WIDTH];
   assign w_ld_ofl  = ~w_mul_done & w_ofl;
   assign w_ld_zero = ~|w_ld_out;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_cout      <= 1'b0;
         r_ofl       <= 1'b0;
         r_zero      <= 1'b0;
         r_gzero     <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out       <= w_ld_out;
         r_cout      <= w_ld_cout;
         r_ofl       <= w_ld_ofl;
         r_zero      <= w_ld_zero;
         r_gzero     <= ~w_ld_zero & ~(w_ld_out[WIDTH-1] ^ w_ld_ofl);
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
   assign out_valid = r_out_valid;
   assign out       = r_out;
   assign cOut      = r_cout;
   assign ofl       = r_ofl;
   assign zero      = r_zero;
   assign gZero     = r_gzero;
endmodule

// File: tb/tb_alu_pipe_nb.sv
// tb_alu_pipe_nb: scoreboard bench for alu_pipe_nb (WIDTH=16); honours ALU_MUL_EN like the design.
module tb_alu_pipe_nb;
   localparam int W = 16;
   logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, neg1 = 1'b0, neg2 = 1'b0;
   logic [W-1:0] in1 = '0, in2 = '0;
   logic [3:0]   op = '0;
   logic         in_ready, out_valid, cOut, ofl, zero, gZero;
   logic [W-1:0] out;
   typedef struct packed {logic [W-1:0] v; logic c, o, z, g;} res_t;
   typedef struct packed {logic [W-1:0] a, b; logic [3:0] o; logic n1, n2; res_t e;} vec_t;
   res_t q[$];
   res_t got, e;
   int   n_tests = 0, n_fail = 0;
   assign got = {out, cOut, ofl, zero, gZero};
   always #5 clk = ~clk;

   alu_pipe_nb #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
      .op(op), .neg1(neg1), .neg2(neg2), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .cOut(cOut), .ofl(ofl), .zero(zero), .gZero(gZero)
   );

   function automatic res_t model(input logic [W-1:0] i1, i2, input logic [3:0] o, input logic n1, n2);
      logic [W-1:0]   a, b, r;
      logic [W:0]     s;
      logic [2*W-1:0] p;
      logic           c, ov;
      int             sh;
      res_t           m;
      a = n1 ? W'(0) - i1 : i1;
      b = n2 ? ~i2 : i2;
      sh = int'(b[3:0]);
      r = '0; c = 1'b0; ov = 1'b0; p = '0;
      case (o[3:2])
         2'b00: begin
            r = a;
            for (int k = 0; k < sh; k++)
               case (o[1:0])
                  2'b00: r = {r[W-2:0], r[W-1]};
                  2'b01: r = {r[W-2:0], 1'b0};
                  2'b10: r = {r[0], r[W-1:1]};
                  default: r = {1'b0, r[W-1:1]};
               endcase
         end
         2'b01: case (o[1:0])
            2'b00: begin
               s = a + b; r = s[W-1:0]; c = s[W];
               ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            2'b01: r = a & b;
            2'b10: r = a ^ b;
            default: begin
`ifdef ALU_MUL_EN
               p = a * b; r = p[W-1:0]; c = |p[2*W-1:W];
`endif
            end
         endcase
         2'b10: for (int k = 0; k < W; k++) r[k] = a[W-1-k];
         default: r = {a[7:0], b[7:0]};
      endcase
      m.v = r; m.c = c; m.o = ov; m.z = (r == 0); m.g = (r != 0) && !(r[W-1] ^ ov);
      return m;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [W-1:0] a, b, input logic [3:0] o, input logic n1, n2);
      in1 = a; in2 = b; op = o; neg1 = n1; neg2 = n2; in_valid = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0;
      tick; tick;
      n_tests++;
      if (got !== '0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: out_valid=%b res=%h required out_valid=0 res=0", out_valid, got);
      end
      rst = 1'b0;
      tick;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_vectors;
      vec_t tv[17];
      tv[0]  = '{16'h0005, 16'h0003, 4'b0100, 1'b0, 1'b0, '{16'h0008, 1'b0, 1'b0, 1'b0, 1'b1}};
      tv[1]  = '{16'h0005, 16'h0005, 4'b0100, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
      tv[2]  = '{16'h7FFF, 16'h0001, 4'b0100, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}};
      tv[3]  = '{16'h00AB, 16'h12CD, 4'b1100, 1'b0, 1'b0, '{16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0}};
      tv[4]  = '{16'h8001, 16'h0001, 4'b0000, 1'b0, 1'b0, '{16'h0003, 1'b0, 1'b0, 1'b0, 1'b1}};
      tv[5]  = '{16'h8000, 16'h000F, 4'b0011, 1'b0, 1'b0, '{16'h0001, 1'b0, 1'b0, 1'b0, 1'b1}};
      tv[6]  = '{16'h0001, 16'h0001, 4'b0010, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b0, 1'b0, 1'b0}};
      tv[7]  = '{16'h0001, 16'h0011, 4'b0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0, 1'b1}};
      tv[8]  = '{16'h1234, 16'h0010, 4'b0000, 1'b0, 1'b0, '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b1}};
      tv[9]  = '{16'hF0F0, 16'hFF00, 4'b0101, 1'b0, 1'b0, '{16'hF000, 1'b0, 1'b0, 1'b0, 1'b0}};
      tv[10] = '{16'h00FF, 16'h00FF, 4'b0110, 1'b0, 1'b1, '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
      tv[11] = '{16'h0001, 16'h0000, 4'b1000, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b0, 1'b0, 1'b0}};
      tv[12] = '{16'h8000, 16'h8000, 4'b0100, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b0}};
      tv[13] = '{16'hFFFF, 16'hFFFF, 4'b0100, 1'b0, 1'b0, '{16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0}};
      tv[14] = '{16'h8000, 16'hFFFF, 4'b0100, 1'b0, 1'b0, '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0}};
      tv[15] = '{16'h8001, 16'h0000, 4'b0010, 1'b0, 1'b0, '{16'h8001, 1'b0, 1'b0, 1'b0, 1'b0}};
      tv[16] = '{16'h8000, 16'h0000, 4'b0100, 1'b1, 1'b0, '{16'h8000, 1'b0, 1'b0, 1'b0, 1'b0}};
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         put(tv[i].a, tv[i].b, tv[i].o, tv[i].n1, tv[i].n2);
         q.push_back(tv[i].e);
         tick;
         in_valid = 1'b0;
         e = q.pop_front();
         n_tests++;
         if (out_valid !== 1'b1 || got !== e) begin
            n_fail++; $display("FAIL vector%0d: out_valid=%b res=%h required out_valid=1 res=%h", i, out_valid, got, e);
         end
      end
      tick;
   endtask

   task automatic test_random;
      logic [W-1:0] a, b;
      logic [3:0]   o;
      logic         n1, n2;
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom); b = W'($urandom); o = 4'($urandom_range(0, 15));
         n1 = 1'($urandom); n2 = 1'($urandom);
         if (o == 4'b0111) o = 4'b0100;
         put(a, b, o, n1, n2);
         q.push_back(model(a, b, o, n1, n2));
         tick;
         in_valid = 1'b0;
         e = q.pop_front();
         n_tests++;
         if (out_valid !== 1'b1 || got !== e) begin
            n_fail++; $display("FAIL random%0d op=%b: res=%h required %h", i, o, got, e);
         end
      end
      tick;
   endtask

   task automatic test_mul;
`ifdef ALU_MUL_EN
      logic [W-1:0] ma[2], mb[2];
      ma[0] = 16'h0012; mb[0] = 16'h0034;
      ma[1] = 16'hFFFF; mb[1] = 16'h0002;
      out_ready = 1'b1;
      for (int t = 0; t < 2; t++) begin
         put(ma[t], mb[t], 4'b0111, 1'b0, 1'b0);
         q.push_back(t == 0 ? res_t'({16'h03A8, 1'b0, 1'b0, 1'b0, 1'b1}) : res_t'({16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0}));
         tick;
         put(16'hFFFF, 16'h1111, 4'b0100, 1'b0, 1'b0);
         for (int i = 1; i < W; i++) begin
            if (i == 10) in_valid = 1'b0;
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
               n_fail++; $display("FAIL mul_busy%0d c%0d: out_valid=%b in_ready=%b required 0/0", t, i, out_valid, in_ready);
            end
            tick;
         end
         n_tests++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mul_early%0d: out_valid=%b required 0", t, out_valid);
         end
         tick;
         e = q.pop_front();
         n_tests++;
         if (out_valid !== 1'b1 || got !== e) begin
            n_fail++; $display("FAIL mul_result%0d: out_valid=%b res=%h required 1 res=%h", t, out_valid, got, e);
         end
      end
`else
      out_ready = 1'b1;
      put(16'h0012, 16'h0034, 4'b0111, 1'b0, 1'b0);
      q.push_back({16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
      tick;
      in_valid = 1'b0;
      e = q.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || got !== e) begin
         n_fail++; $display("FAIL mul_disabled: out_valid=%b res=%h required 1 res=%h", out_valid, got, e);
      end
`endif
      tick;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      put(16'h0005, 16'h0003, 4'b0100, 1'b0, 1'b0);
      q.push_back({16'h0008, 1'b0, 1'b0, 1'b0, 1'b1});
      tick;
      put(16'h1111, 16'h1111, 4'b0100, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== q[0]) begin
            n_fail++; $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b res=%h required 1/0 res=%h", i, out_valid, in_ready, got, q[0]);
         end
         tick;
      end
      out_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: in_ready=%b required 1", in_ready);
      end
      q.push_back({16'h2222, 1'b0, 1'b0, 1'b0, 1'b1});
      e = q.pop_front();
      tick;
      in_valid = 1'b0;
      e = q.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || got !== e) begin
         n_fail++; $display("FAIL bp_drain_load: out_valid=%b res=%h required 1 res=%h", out_valid, got, e);
      end
      tick;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_empty: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] a, b;
      logic [3:0]   o;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = W'($urandom); b = W'($urandom); o = 4'(i == 7 ? 12 : i % 7);
         put(a, b, o, 1'b0, 1'b0);
         q.push_back(model(a, b, o, 1'b0, 1'b0));
         #1;
         n_tests++;
         if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready%0d: in_ready=%b required 1", i, in_ready);
         end
         tick;
         e = q.pop_front();
         n_tests++;
         if (out_valid !== 1'b1 || got !== e) begin
            n_fail++; $display("FAIL b2b%0d: out_valid=%b res=%h required 1 res=%h", i, out_valid, got, e);
         end
      end
      in_valid = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid;
`ifdef ALU_MUL_EN
      out_ready = 1'b1;
      put(16'h0012, 16'h0034, 4'b0111, 1'b0, 1'b0);
      tick;
      in_valid = 1'b0;
      tick; tick; tick;
`else
      out_ready = 1'b0;
      put(16'h0012, 16'h0034, 4'b0100, 1'b0, 1'b0);
      tick;
      in_valid = 1'b0;
`endif
      rst = 1'b1;
      tick;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < W + 2; i++) begin
         tick;
         n_tests++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_abort c%0d: out_valid=%b required 0", i, out_valid);
         end
      end
      put(16'h0005, 16'h0003, 4'b0100, 1'b0, 1'b0);
      q.push_back({16'h0008, 1'b0, 1'b0, 1'b0, 1'b1});
      tick;
      in_valid = 1'b0;
      e = q.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || got !== e) begin
         n_fail++; $display("FAIL rst_after_add: out_valid=%b res=%h required 1 res=%h", out_valid, got, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_vectors;
      test_random;
      test_mul;
      test_backpressure;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
